// File: rtl/multi_counter_fsm.sv
// multi_counter_fsm: NUM_CH independent "run for N ticks, then pulse done"
// sequencers. Every channel has its own captured terminal count, its mode
// (one-shot or auto-reload) and an IDLE/RUN/DONE state machine. All channels
// advance only on the shared tick enable.
module multi_counter_fsm #(
  parameter int CNT_WIDTH = 7,
  parameter int NUM_CH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_i,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             abort_i,
  input  logic [NUM_CH-1:0]             mode_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   cnt_val_i,
  output logic [NUM_CH-1:0]             idle_o,
  output logic [NUM_CH-1:0]             run_o,
  output logic [NUM_CH-1:0]             done_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_o,
  output logic                          any_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] val_q, val_d;
    logic                 mode_q, mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [CNT_WIDTH-1:0] val_in;
    logic                 last_tick;
    logic                 idle_s, run_s, done_s;
    logic [CNT_WIDTH-1:0] cnt_s;

    assign val_in = cnt_val_i[ch*CNT_WIDTH +: CNT_WIDTH];

    // The RUN phase ends on the tick that would take the count to val_q.
    // val_q is never 0 in RUN, so the subtraction never wraps in use.
    assign last_tick = (cnt_q == (val_q - CNT_ONE));

    // State and captured-register storage, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        val_q   <= '0;
        mode_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every register updating from
        // the pre-edge values, independent of statement order.
        state_q <= state_d;
        val_q   <= val_d;
        mode_q  <= mode_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state and next-register values; abort beats start beats count.
    always_comb begin
      // NOTE: hold-by-default assignments first so no path through the case
      // leaves a variable unassigned, which would infer a latch.
      state_d = state_q;
      val_d   = val_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;

      case (state_q)
        ST_IDLE: begin
          if (!abort_i[ch] && start_i[ch]) begin
            val_d   = val_in;
            mode_d  = mode_i[ch];
            cnt_d   = '0;
            state_d = (val_in != '0) ? ST_RUN : ST_DONE;
          end
        end

        ST_RUN: begin
          if (abort_i[ch]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (tick_i) begin
            if (last_tick) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          cnt_d = '0;
          if (abort_i[ch]) begin
            state_d = ST_IDLE;
          end else if (start_i[ch]) begin
            val_d   = val_in;
            mode_d  = mode_i[ch];
            state_d = (val_in != '0) ? ST_RUN : ST_DONE;
          end else if (mode_q) begin
            // Auto-reload: a zero count keeps pulsing done every cycle.
            state_d = (val_q != '0) ? ST_RUN : ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Status outputs decode the state register directly.
    always_comb begin
      idle_s = 1'b0;
      run_s  = 1'b0;
      done_s = 1'b0;
      cnt_s  = '0;
      case (state_q)
        ST_RUN: begin
          run_s = 1'b1;
          cnt_s = cnt_q;
        end
        ST_DONE: done_s = 1'b1;
        default: idle_s = 1'b1;
      endcase
    end

    assign idle_o[ch]                         = idle_s;
    assign run_o[ch]                          = run_s;
    assign done_o[ch]                         = done_s;
    assign cnt_o[ch*CNT_WIDTH +: CNT_WIDTH]   = cnt_s;

  end : g_ch

  assign any_done_o = |done_o;

endmodule : multi_counter_fsm

// File: doc/multi_counter_fsm.md
# multi_counter_fsm

Parametrised, multi-channel successor to the team's single-channel counter state machine. Each of NUM_CH channels has its own internal counter, IDLE/RUN/DONE sequencer, captured terminal count and mode. Channels run in one-shot or auto-reload mode, can be aborted, and advance only on a shared tick enable. The block sits between control registers or sequencer logic and the datapath blocks that need "run for N ticks, then signal done" timing.

## Interface
Parameters:
- CNT_WIDTH, 7, width of each terminal count and each counter.
- NUM_CH, 4, number of independent channels (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick_i  in  1  global count enable; counters advance only when 1.
- start_i  in  NUM_CH  per-channel start request, level-sampled each clk edge.
- abort_i  in  NUM_CH  per-channel abort request.
- mode_i  in  NUM_CH  per-channel mode, captured with start: 0 = one-shot, 1 = auto-reload.
- cnt_val_i  in  NUM_CH*CNT_WIDTH  per-channel terminal count; channel k uses bits [k*CNT_WIDTH +: CNT_WIDTH].
- idle_o  out  NUM_CH  channel in IDLE.
- run_o  out  NUM_CH  channel in RUN.
- done_o  out  NUM_CH  channel in DONE; one-cycle pulse per completion.
- cnt_o  out  NUM_CH*CNT_WIDTH  per-channel current count, same packing as cnt_val_i.
- any_done_o  out  1  OR of done_o.

## Operation
- Channels are fully independent; none of the following rules couples one channel to another.
- States: IDLE, RUN, DONE. Outputs decode the state register directly; exactly one of idle_o/run_o/done_o is 1 per channel.
- Captured registers per channel: val_q (CNT_WIDTH), mode_q (1), cnt_q (CNT_WIDTH).
- Priority per channel, per edge: abort > start > count.
- IDLE:
  - start_i=1 and abort_i=0: capture val_q←cnt_val_i and mode_q←mode_i; cnt_q←0.
    - If cnt_val_i≠0, go to RUN.
    - If cnt_val_i=0, go directly to DONE (zero-length run).
  - abort_i=1: stay in IDLE. A simultaneous start is ignored.
- RUN:
  - abort_i=1: go to IDLE; cnt_q←0.
  - tick_i=1 and cnt_q==val_q−1: go to DONE; cnt_q←0.
  - tick_i=1 otherwise: cnt_q←cnt_q+1.
  - tick_i=0: hold.
  - start_i is ignored in RUN. No retrigger, no recapture.
- DONE (always lasts exactly one cycle):
  - abort_i=1: go to IDLE.
  - start_i=1: recapture val_q/mode_q, then follow the IDLE start rules (RUN, or DONE again if cnt_val_i=0).
  - mode_q=1: go to RUN with cnt_q=0 and the same val_q. If val_q=0, go to DONE again, giving a done_o pulse every cycle.
  - mode_q=0: go to IDLE.
- val_q−1 is computed modulo 2^CNT_WIDTH. val_q=0 never reaches RUN, so no wrap compare occurs.
- The maximum count is val_q=2^CNT_WIDTH−1; cnt_q never wraps.
- cnt_o reflects cnt_q and reads 0 in IDLE and DONE.

## Timing
- Reset (async assert, sync to clk on deassert):
  - idle_o all 1; run_o, done_o, cnt_o, any_done_o all 0.
  - val_q and mode_q cleared.
- Start sampled at edge E0 with cnt_val_i=N≥1 and tick_i held 1:
  - run_o=1 after E0 for exactly N cycles; cnt_o steps 0,1,…,N−1.
  - done_o=1 for the single cycle after E_N.
  - One-shot: idle_o=1 after E_{N+1}.
  - Auto-reload: run_o=1 again after E_{N+1}; the period is N+1 cycles.
- Gated tick: the RUN duration equals the number of cycles with tick_i=1 while in RUN, which must reach N.
- Abort: state is IDLE one edge after abort_i is sampled. No done_o pulse is generated.
- any_done_o is combinational from done_o and has the same cycle.
- Mid-operation reset returns every channel to IDLE immediately with no done_o pulse.

## Test plan
- Reset check: hold rst_n=0 with random inputs → idle_o=all 1, run_o=0, done_o=0, cnt_o=0. Release, then start ch0 with N=5, tick_i=1 → run_o[0] for 5 cycles, done_o[0] pulse on cycle 6, idle on cycle 7.
- Auto-reload: ch1 with mode=1, N=3, tick_i=1 for 12 cycles → done_o[1] pulses every 4th cycle (3 pulses); cnt_o[1] repeats 0,1,2. Then abort → IDLE next cycle, no further pulses.
- Tick gating and start ignored in RUN: ch2 with N=4, tick_i toggling 1,0,1,0… → DONE after 4 ticks (about 8 cycles). A start_i[2] pulse mid-RUN with cnt_val_i=9 changes neither duration nor val_q.
- Boundaries:
  - N=0 → done_o pulse on the cycle after start; one-shot returns to IDLE.
  - N=2^CNT_WIDTH−1 (127) → 127 RUN cycles, no wrap.
  - Simultaneous start+abort in IDLE → stays in IDLE.
- Restart from DONE: start_i asserted during the DONE cycle with a new N=2 and mode=0 → RUN for 2 cycles, then a second DONE pulse.
- Independence and reset: all 4 channels started with N=1,2,3,4 → each done_o fires at its own cycle and any_done_o is their OR. Asserting rst_n mid-run clears all channels immediately.
